// File: rtl/sweep_frequency_controller.sv
// sweep_frequency_controller
//
// Steps a 48-bit tuning word from a start value towards a stop value in
// fixed increments, holding each value for a programmable number of cycles.
// Sweep parameters are captured when the sweep starts, so the programming
// registers may be rewritten while a sweep runs. Direction is implied by the
// ordering of start and stop. Continuous mode restarts the sweep from the
// start value whenever the stop value has been held for its full dwell.
//
// Ports
//   Clock       system clock, rising-edge active
//   Reset       asynchronous active-low reset
//   Start_Freq  sweep start tuning word
//   Stop_Freq   sweep stop tuning word
//   Step_Freq   unsigned step magnitude
//   Dwell       cycles each tuning word is held (0 behaves as 1)
//   Start       sweep request, honoured only when idle
//   Abort       sweep cancel, honoured in every state
//   Continuous  restart at the sweep end instead of finishing
//   Dout        current tuning word
//   Freq_Valid  one-cycle pulse in the first cycle a new Dout value appears
//   Busy        high while a sweep is running
//   Done        one-cycle pulse when a single sweep finishes

module sweep_frequency_controller (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [47:0] Start_Freq,
  input  logic [47:0] Stop_Freq,
  input  logic [47:0] Step_Freq,
  input  logic [31:0] Dwell,
  input  logic        Start,
  input  logic        Abort,
  input  logic        Continuous,
  output logic [47:0] Dout,
  output logic        Freq_Valid,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    StIdle,
    StDwell,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Shadow copies of the sweep parameters, captured on Start.
  logic [47:0] start_q, start_d;
  logic [47:0] stop_q,  stop_d;
  logic [47:0] step_q,  step_d;
  logic [31:0] dwell_q, dwell_d;

  logic [47:0] dout_q, dout_d;
  logic [31:0] cnt_q,  cnt_d;
  logic        fvalid_q, fvalid_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  logic        dir_up;
  logic [31:0] dwell_last;
  logic        expired;
  logic        at_stop;
  logic [48:0] sum_up;
  logic [48:0] diff_dn;
  logic [47:0] next_up;
  logic [47:0] next_dn;
  logic [47:0] next_freq;

  assign dir_up     = (start_q <= stop_q);
  // Counter value in the last cycle of a dwell; a zero dwell holds one cycle.
  assign dwell_last = (dwell_q == 32'd0) ? 32'd0 : (dwell_q - 32'd1);
  assign expired    = (cnt_q >= dwell_last);
  assign at_stop    = (dout_q == stop_q);

  // One extra bit so a carry (up) or borrow (down) is visible and clamps to stop.
  assign sum_up  = {1'b0, dout_q} + {1'b0, step_q};
  assign diff_dn = {1'b0, dout_q} - {1'b0, step_q};

  always_comb begin
    next_up = (sum_up > {1'b0, stop_q}) ? stop_q : sum_up[47:0];
    next_dn = (diff_dn[48] || (diff_dn[47:0] < stop_q)) ? stop_q : diff_dn[47:0];
    // A zero step jumps straight to stop so the sweep cannot stall.
    if (step_q == 48'd0) begin
      next_freq = stop_q;
    end else if (dir_up) begin
      next_freq = next_up;
    end else begin
      next_freq = next_dn;
    end
  end

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (Abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            state_d = StDwell;
          end
        end
        StDwell: begin
          if (expired && at_stop && !Continuous) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Output and datapath next-state logic; all outputs are registered.
  always_comb begin
    start_d  = start_q;
    stop_d   = stop_q;
    step_d   = step_q;
    dwell_d  = dwell_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    fvalid_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;

    if (Abort) begin
      // Dout keeps its value; no pulses are produced.
      busy_d = 1'b0;
      cnt_d  = 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            start_d  = Start_Freq;
            stop_d   = Stop_Freq;
            step_d   = Step_Freq;
            dwell_d  = Dwell;
            dout_d   = Start_Freq;
            fvalid_d = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = 32'd0;
          end
        end
        StDwell: begin
          if (!expired) begin
            cnt_d = cnt_q + 32'd1;
          end else if (!at_stop) begin
            dout_d   = next_freq;
            fvalid_d = 1'b1;
            cnt_d    = 32'd0;
          end else if (Continuous) begin
            dout_d   = start_q;
            fvalid_d = 1'b1;
            cnt_d    = 32'd0;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
            cnt_d  = 32'd0;
          end
        end
        StDone: begin
          busy_d = 1'b0;
        end
        default: begin
          busy_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      start_q  <= 48'd0;
      stop_q   <= 48'd0;
      step_q   <= 48'd0;
      dwell_q  <= 32'd0;
      dout_q   <= 48'd0;
      cnt_q    <= 32'd0;
      fvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      start_q  <= start_d;
      stop_q   <= stop_d;
      step_q   <= step_d;
      dwell_q  <= dwell_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      fvalid_q <= fvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Dout       = dout_q;
  assign Freq_Valid = fvalid_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_sweep_frequency_controller.sv
module tb_sweep_frequency_controller;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [47:0] Start_Freq;
  logic [47:0] Stop_Freq;
  logic [47:0] Step_Freq;
  logic [31:0] Dwell;
  logic        Start;
  logic        Abort;
  logic        Continuous;
  logic [47:0] Dout;
  logic        Freq_Valid;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_errors = 0;

  sweep_frequency_controller u_dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start_Freq (Start_Freq),
    .Stop_Freq  (Stop_Freq),
    .Step_Freq  (Step_Freq),
    .Dwell      (Dwell),
    .Start      (Start),
    .Abort      (Abort),
    .Continuous (Continuous),
    .Dout       (Dout),
    .Freq_Valid (Freq_Valid),
    .Busy       (Busy),
    .Done       (Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step_clk();
    @(posedge Clock);
    #1;
  endtask

  task automatic scramble_inputs();
    Start_Freq = {16'($urandom), $urandom};
    Stop_Freq  = {16'($urandom), $urandom};
    Step_Freq  = {16'($urandom), $urandom};
    Dwell      = $urandom;
  endtask

  // Reference: list every tuning word of a one-shot sweep by plain arithmetic,
  // then expect each for max(dwell,1) cycles followed by a one-cycle Done.
  task automatic run_sweep(input logic [47:0] s, input logic [47:0] p,
                           input logic [47:0] st, input logic [31:0] dw);
    logic [63:0] q[$];
    logic [63:0] v;
    int          hold;
    int          busy_cycles;
    hold = (dw == 0) ? 1 : int'(dw);
    v = 64'(s);
    q.push_back(v);
    while (v != 64'(p)) begin
      if (s <= p) v = (st == 0 || v + 64'(st) > 64'(p)) ? 64'(p) : v + 64'(st);
      else        v = (st == 0 || 64'(st) > v - 64'(p)) ? 64'(p) : v - 64'(st);
      q.push_back(v);
    end
    Start_Freq = s;
    Stop_Freq  = p;
    Step_Freq  = st;
    Dwell      = dw;
    Continuous = 1'b0;
    Start      = 1'b1;
    step_clk();
    Start = 1'b0;
    scramble_inputs();
    busy_cycles = 0;
    foreach (q[i]) begin
      for (int k = 0; k < hold; k++) begin
        chk("sweep_dout", 64'(Dout), q[i]);
        chk("sweep_fvalid", 64'(Freq_Valid), 64'(k == 0));
        chk("sweep_busy", 64'(Busy), 64'd1);
        chk("sweep_done", 64'(Done), 64'd0);
        busy_cycles += int'(Busy);
        step_clk();
      end
    end
    chk("end_done", 64'(Done), 64'd1);
    chk("end_busy", 64'(Busy), 64'd0);
    chk("end_dout", 64'(Dout), 64'(p));
    chk("end_fvalid", 64'(Freq_Valid), 64'd0);
    chk("busy_cycles", 64'(busy_cycles), 64'(q.size() * hold));
    step_clk();
    chk("done_clear", 64'(Done), 64'd0);
    chk("idle_dout", 64'(Dout), 64'(p));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] hi;
    logic [47:0] rs, rp, rst;
    Reset      = 1'b0;
    Start      = 1'b0;
    Abort      = 1'b0;
    Continuous = 1'b0;
    Start_Freq = 48'd0;
    Stop_Freq  = 48'd0;
    Step_Freq  = 48'd0;
    Dwell      = 32'd0;
    step_clk();
    step_clk();
    chk("rst_dout", 64'(Dout), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_fvalid", 64'(Freq_Valid), 64'd0);
    Reset = 1'b1;
    step_clk();
    chk("post_rst_busy", 64'(Busy), 64'd0);

    // Directed sweeps
    run_sweep(48'd100, 48'd130, 48'd10, 32'd3);
    run_sweep(48'd50, 48'd20, 48'd40, 32'd0);
    run_sweep(48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFFF, 48'h20, 32'd1);
    run_sweep(48'd5, 48'd9, 48'd0, 32'd2);
    run_sweep(48'd7, 48'd7, 48'd3, 32'd2);
    run_sweep(48'd30, 48'd0, 48'd7, 32'd1);

    // Randomized one-shot sweeps, some near the top of the range
    for (int n = 0; n < 20; n++) begin
      hi  = ($urandom_range(0, 1) == 1) ? 48'hFFFF_FFFF_FF00 : 48'd0;
      rs  = hi + 48'($urandom_range(0, 255));
      rp  = hi + 48'($urandom_range(0, 255));
      rst = ($urandom_range(0, 3) == 0) ? {16'($urandom), $urandom}
                                         : 48'($urandom_range(0, 80));
      run_sweep(rs, rp, rst, 32'($urandom_range(0, 4)));
    end

    // Continuous: 0,1,2 repeating, then drop Continuous before the last 2 expires
    Start_Freq = 48'd0;
    Stop_Freq  = 48'd2;
    Step_Freq  = 48'd1;
    Dwell      = 32'd1;
    Continuous = 1'b1;
    Start      = 1'b1;
    step_clk();
    Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("cont_dout", 64'(Dout), 64'(i % 3));
      chk("cont_fvalid", 64'(Freq_Valid), 64'd1);
      chk("cont_busy", 64'(Busy), 64'd1);
      chk("cont_done", 64'(Done), 64'd0);
      if (i == 7) Continuous = 1'b0;
      step_clk();
    end
    chk("cont_last_dout", 64'(Dout), 64'd2);
    chk("cont_last_done", 64'(Done), 64'd0);
    step_clk();
    chk("cont_end_done", 64'(Done), 64'd1);
    chk("cont_end_busy", 64'(Busy), 64'd0);
    chk("cont_end_dout", 64'(Dout), 64'd2);
    step_clk();
    chk("cont_done_clear", 64'(Done), 64'd0);

    // Abort during the second dwell of the up sweep
    Start_Freq = 48'd100;
    Stop_Freq  = 48'd130;
    Step_Freq  = 48'd10;
    Dwell      = 32'd3;
    Start      = 1'b1;
    step_clk();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ab_first_dout", 64'(Dout), 64'd100);
      step_clk();
    end
    chk("ab_second_dout", 64'(Dout), 64'd110);
    Abort = 1'b1;
    step_clk();
    Abort = 1'b0;
    chk("ab_busy", 64'(Busy), 64'd0);
    chk("ab_dout", 64'(Dout), 64'd110);
    chk("ab_fvalid", 64'(Freq_Valid), 64'd0);
    chk("ab_done", 64'(Done), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step_clk();
      chk("ab_idle_busy", 64'(Busy), 64'd0);
      chk("ab_idle_done", 64'(Done), 64'd0);
      chk("ab_idle_dout", 64'(Dout), 64'd110);
    end
    Start_Freq = 48'd500;
    Start      = 1'b1;
    Abort      = 1'b1;
    step_clk();
    Start = 1'b0;
    Abort = 1'b0;
    chk("ab_both_busy", 64'(Busy), 64'd0);
    chk("ab_both_fvalid", 64'(Freq_Valid), 64'd0);
    chk("ab_both_dout", 64'(Dout), 64'd110);
    step_clk();
    chk("ab_both_idle", 64'(Busy), 64'd0);
    chk("ab_both_idle_dout", 64'(Dout), 64'd110);

    // Start ignored while busy, then reset mid-dwell
    Start_Freq = 48'd100;
    Stop_Freq  = 48'd130;
    Step_Freq  = 48'd10;
    Dwell      = 32'd3;
    Start      = 1'b1;
    step_clk();
    Start_Freq = 48'd999;
    step_clk();
    Start = 1'b0;
    chk("busy_start_dout", 64'(Dout), 64'd100);
    chk("busy_start_fvalid", 64'(Freq_Valid), 64'd0);
    chk("busy_start_busy", 64'(Busy), 64'd1);
    step_clk();
    step_clk();
    chk("pre_rst_dout", 64'(Dout), 64'd110);
    Reset = 1'b0;
    #2;
    chk("async_rst_dout", 64'(Dout), 64'd0);
    chk("async_rst_busy", 64'(Busy), 64'd0);
    chk("async_rst_done", 64'(Done), 64'd0);
    chk("async_rst_fvalid", 64'(Freq_Valid), 64'd0);
    step_clk();
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step_clk();
      chk("post_rst_idle_busy", 64'(Busy), 64'd0);
      chk("post_rst_idle_dout", 64'(Dout), 64'd0);
      chk("post_rst_idle_fvalid", 64'(Freq_Valid), 64'd0);
    end
    run_sweep(48'd3, 48'd1, 48'd1, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
